// File: rtl/sm_result_collector_pkg.sv
// Shared widths and lane encoding for the two-lane score result collector.
// Record layout toward the ScoreBank is {id, score}, id in the upper bits.
package sm_result_collector_pkg;

  localparam int unsigned DEF_ID_WIDTH    = 48;
  localparam int unsigned DEF_SCORE_WIDTH = 16;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/sm_result_fifo.sv
// Result fifo: head is read straight from the storage registers; push and pop
// in the same cycle are allowed even when full.
module sm_result_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_we;
  logic             do_re;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_re = re & ~empty;
  assign do_we = we & (~full | do_re);
  assign out   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_we) wr_ptr <= wr_ptr + AW'(1);
      if (do_re) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_we) - (AW+1)'(do_re);
    end
  end

  always_ff @(posedge clk) begin
    if (do_we) mem[wr_ptr] <= in;
  end

endmodule

// File: rtl/sm_result_collector.sv
// Pairs per-lane scores with feeder IDs, filters by threshold, and merges the
// two lanes into one result fifo through a round-robin arbiter.
module sm_result_collector
  import sm_result_collector_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld0,
  input  logic [SCORE_WIDTH-1:0] score0,
  input  logic [ID_WIDTH-1:0]    id0,
  output logic                   re0,
  input  logic                   vld1,
  input  logic [SCORE_WIDTH-1:0] score1,
  input  logic [ID_WIDTH-1:0]    id1,
  output logic                   re1,
  output logic                   busy0,
  output logic                   busy1,
  input  logic [SCORE_WIDTH-1:0] thresh,
  output logic                   out_valid,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic [SCORE_WIDTH-1:0] out_score,
  input  logic                   out_ready,
  output logic                   err,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);

  localparam int unsigned RW = ID_WIDTH + SCORE_WIDTH;

  logic [SCORE_WIDTH-1:0] score_a [2];
  logic [ID_WIDTH-1:0]    id_a    [2];
  logic [RW-1:0]          slot_rec[2];
  logic [1:0]             slot_full;
  lane_e                  rr;

  logic [1:0]     vld, busy, acc, pass, load, drop, lost, grant;
  logic           can_write;
  logic           fifo_we, fifo_pop, fifo_full, fifo_empty;
  logic [RW-1:0]  fifo_in, fifo_out;
  logic [1:0]     drop_inc;
  logic [CNT_WIDTH:0] drop_sum;

  assign vld        = {vld1, vld0};
  assign score_a[0] = score0;
  assign score_a[1] = score1;
  assign id_a[0]    = id0;
  assign id_a[1]    = id1;

  assign fifo_pop  = ~fifo_empty & out_ready;
  assign can_write = ~fifo_full | fifo_pop;

  // Single full slot wins outright; both full goes to the round-robin lane.
  always_comb begin
    grant = '0;
    if (can_write) begin
      if (&slot_full) begin
        if (rr == LANE0) grant[0] = 1'b1;
        else             grant[1] = 1'b1;
      end else begin
        grant = slot_full;
      end
    end
  end

  always_comb begin
    busy = slot_full & ~grant;
    acc  = vld & ~busy & {2{rst}};
    lost = vld & busy;
    for (int i = 0; i < 2; i++) pass[i] = (score_a[i] >= thresh);
    load = acc & pass;
    drop = acc & ~pass;
  end

  assign re0   = acc[0];
  assign re1   = acc[1];
  assign busy0 = busy[0] & rst;
  assign busy1 = busy[1] & rst;

  assign drop_inc = 2'(drop[0]) + 2'(drop[1]);
  assign drop_sum = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(drop_inc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_full <= '0;
      rr        <= LANE0;
      err       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i])       slot_full[i] <= 1'b1;
        else if (grant[i]) slot_full[i] <= 1'b0;
      end
      if ((&slot_full) && can_write) rr <= (rr == LANE0) ? LANE1 : LANE0;
      if (|lost) err <= 1'b1;
      drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load[i]) slot_rec[i] <= {id_a[i], score_a[i]};
    end
  end

  assign fifo_we = |grant;
  assign fifo_in = grant[1] ? slot_rec[1] : slot_rec[0];

  sm_result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (fifo_we),
    .re    (fifo_pop),
    .in    (fifo_in),
    .out   (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_id    = fifo_out[RW-1:SCORE_WIDTH];
  assign out_score = fifo_out[SCORE_WIDTH-1:0];

endmodule
